// File: rtl/bcd_time_pkg.sv
// Shared constants and helpers for the hh:mm:ss BCD time counter.
// Optional alarm feature in the top is enabled by defining BCD_TIME_ALARM_EN.
package bcd_time_pkg;

    localparam int FIELD_W = 8;

    typedef logic [FIELD_W-1:0] bcd_field_t;

    localparam bcd_field_t FIELD_MIN   = 8'h00;
    localparam bcd_field_t SEC_MAX     = 8'h59;
    localparam bcd_field_t MIN_MAX     = 8'h59;
    localparam bcd_field_t HOUR24_MAX  = 8'h23;
    localparam bcd_field_t HOUR12_MAX  = 8'h12;
    localparam bcd_field_t HOUR12_MIN  = 8'h01;

    localparam logic [3*FIELD_W-1:0] RESET_TIME_24 = 24'h000000;
    localparam logic [3*FIELD_W-1:0] RESET_TIME_12 = 24'h120000;

    // True when both nibbles are decimal digits and the field lies in [lo, hi].
    function automatic logic bcd_field_valid(input bcd_field_t f,
                                             input bcd_field_t lo,
                                             input bcd_field_t hi);
        return (f[7:4] <= 4'd9) && (f[3:0] <= 4'd9) && (f >= lo) && (f <= hi);
    endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// One two-digit BCD field (seconds, minutes or hours) that counts up or down
// between MIN and MAX and reports a wrap when stepped at its boundary.
module bcd_field_counter
    import bcd_time_pkg::*;
#(
    parameter bcd_field_t MIN     = 8'h00,
    parameter bcd_field_t MAX     = 8'h59,
    parameter bcd_field_t RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       up_dn,
    input  logic       load,
    input  bcd_field_t load_val,
    output bcd_field_t q,
    output logic       wrap
);

    logic       at_bound;
    bcd_field_t stepped;
    bcd_field_t q_next;

    // Value one count away from q in the requested direction, wrapping at the bounds.
    always_comb begin
        at_bound = up_dn ? (q == MAX) : (q == MIN);
        if (at_bound) begin
            stepped = up_dn ? MIN : MAX;
        end else if (up_dn) begin
            stepped = (q[3:0] == 4'd9) ? {q[7:4] + 4'd1, 4'd0} : {q[7:4], q[3:0] + 4'd1};
        end else begin
            stepped = (q[3:0] == 4'd0) ? {q[7:4] - 4'd1, 4'd9} : {q[7:4], q[3:0] - 4'd1};
        end
    end

    assign wrap = step & at_bound;

    // Load wins over step; otherwise hold.
    always_comb begin
        if (load) begin
            q_next = load_val;
        end else if (step) begin
            q_next = stepped;
        end else begin
            q_next = q;
        end
    end

    // Field register.
    // NOTE: state is updated with non-blocking assignments so every field
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// hh:mm:ss BCD time counter with 1 s prescaler, up/down counting, 12/24-hour
// mode, validated parallel load and day carry.
// Define BCD_TIME_ALARM_EN to add the alarm_set/alarm_val/alarm ports.
module bcd_time_counter
    import bcd_time_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int HOUR_MOD = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        up_dn,
    input  logic        load,
    input  logic [23:0] load_val,
`ifdef BCD_TIME_ALARM_EN
    input  logic        alarm_set,
    input  logic [23:0] alarm_val,
    output logic        alarm,
`endif
    output logic [23:0] time_bcd,
    output logic        sec_tick,
    output logic        day_carry,
    output logic        load_err
);

    if (HOUR_MOD != 12 && HOUR_MOD != 24) begin : g_bad_hour_mod
        $error("bcd_time_counter: HOUR_MOD must be 12 or 24");
    end
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("bcd_time_counter: TICK_DIV must be at least 2");
    end

    localparam logic [23:0] RESET_TIME = (HOUR_MOD == 12) ? RESET_TIME_12 : RESET_TIME_24;
    localparam bcd_field_t  HOUR_MIN   = (HOUR_MOD == 12) ? HOUR12_MIN : FIELD_MIN;
    localparam bcd_field_t  HOUR_MAX   = (HOUR_MOD == 12) ? HOUR12_MAX : HOUR24_MAX;
    localparam int          PRESC_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc;
    logic               tick_edge;
    logic               load_valid;
    logic               load_ok;
    logic               load_bad;
    logic               step_ss;
    logic               ss_wrap;
    logic               mm_wrap;
    logic               hh_wrap;
    bcd_field_t         ss_q;
    bcd_field_t         mm_q;
    bcd_field_t         hh_q;

    assign tick_edge  = en && (presc == PRESC_LAST);
    assign load_valid = bcd_field_valid(load_val[7:0],   FIELD_MIN, SEC_MAX) &&
                        bcd_field_valid(load_val[15:8],  FIELD_MIN, MIN_MAX) &&
                        bcd_field_valid(load_val[23:16], HOUR_MIN,  HOUR_MAX);
    assign load_ok    = load && load_valid;
    assign load_bad   = load && !load_valid;
    // Any load, valid or not, swallows a coincident tick.
    assign step_ss    = tick_edge && !load;

    bcd_field_counter #(.MIN(FIELD_MIN), .MAX(SEC_MAX), .RST_VAL(RESET_TIME[7:0])) u_ss (
        .clk      (clk),
        .rst      (rst),
        .step     (step_ss),
        .up_dn    (up_dn),
        .load     (load_ok),
        .load_val (load_val[7:0]),
        .q        (ss_q),
        .wrap     (ss_wrap)
    );

    bcd_field_counter #(.MIN(FIELD_MIN), .MAX(MIN_MAX), .RST_VAL(RESET_TIME[15:8])) u_mm (
        .clk      (clk),
        .rst      (rst),
        .step     (ss_wrap),
        .up_dn    (up_dn),
        .load     (load_ok),
        .load_val (load_val[15:8]),
        .q        (mm_q),
        .wrap     (mm_wrap)
    );

    bcd_field_counter #(.MIN(HOUR_MIN), .MAX(HOUR_MAX), .RST_VAL(RESET_TIME[23:16])) u_hh (
        .clk      (clk),
        .rst      (rst),
        .step     (mm_wrap),
        .up_dn    (up_dn),
        .load     (load_ok),
        .load_val (load_val[23:16]),
        .q        (hh_q),
        .wrap     (hh_wrap)
    );

    assign time_bcd = {hh_q, mm_q, ss_q};

    // Prescaler: cleared by a valid load, frozen by a rejected load or en=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (load_ok) begin
            presc <= '0;
        end else if (en && !load) begin
            presc <= tick_edge ? '0 : presc + PRESC_W'(1);
        end
    end

    // Event pulses, registered on the same edge as the time update they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_tick  <= 1'b0;
            day_carry <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            sec_tick  <= step_ss;
            day_carry <= hh_wrap;
            load_err  <= load_bad;
        end
    end

`ifdef BCD_TIME_ALARM_EN
    logic [23:0] alarm_reg;

    // Alarm compare register; all-ones is not a valid BCD time so it never matches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_reg <= 24'hFFFFFF;
        end else if (alarm_set) begin
            alarm_reg <= alarm_val;
        end
    end

    // Qualified by sec_tick, so a load landing on the alarm time stays silent.
    assign alarm = sec_tick && (time_bcd == alarm_reg);
`endif

endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
- Parametrised hh:mm:ss BCD time counter and next-generation replacement for the discrete-counter seconds chain.
- Has an internal prescaler that derives the 1 s tick from the board clock, supports up and down counting, 12/24-hour mode, validated parallel load and a day carry.
- Drives the serial 7-segment driver: time_bcd goes to the digit inputs and sec_tick goes to its start input.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per time step; must be ≥2. Use 4 in simulation.
- HOUR_MOD, 24: 24 gives hours 00..23; 12 gives hours 01..12. Any other value is an elaboration error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  count enable; prescaler and time hold while low.
- up_dn  in  1  1 = count up, 0 = count down; sampled on the tick edge.
- load  in  1  one-cycle load strobe.
- load_val  in  24  BCD {hh,mm,ss} to load.
- time_bcd  out  24  BCD {hh[7:4],hh[3:0],mm,ss}, registered.
- sec_tick  out  1  one-cycle pulse when time_bcd has just changed by counting.
- day_carry  out  1  one-cycle pulse on hour wrap, in either direction.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (async): time_bcd = 24'h000000 when HOUR_MOD=24, 24'h120000 when HOUR_MOD=12. Prescaler = 0; sec_tick, day_carry and load_err = 0.
- Prescaler counts 0..TICK_DIV-1 while en=1. The "tick edge" is the edge where it equals TICK_DIV-1; the prescaler wraps to 0 on that edge.
- On the tick edge (no load):
  - time_bcd steps by one second in the direction of up_dn.
  - sec_tick = 1 in the following cycle only, so it coincides with the new value being visible.
  - Latency from the tick edge to the updated output is 0 cycles (registered on that edge).
- Up counting:
  - ss 59→00 carries into mm; mm 59→00 carries into hh.
  - HOUR_MOD=24: hh 23→00. HOUR_MOD=12: hh 12→01.
  - The hour wrap asserts day_carry together with sec_tick.
  - Low digit 9→0 increments the high digit.
- Down counting:
  - ss 00→59 borrows from mm; mm 00→59 borrows from hh.
  - HOUR_MOD=24: hh 00→23. HOUR_MOD=12: hh 01→12.
  - The hour wrap asserts day_carry.
- Load (load=1) takes priority over the tick in the same cycle. Valid means:
  - every nibble ≤9;
  - ss ≤ 0x59 and mm ≤ 0x59;
  - hh ≤ 0x23 in 24-hour mode, or 0x01 ≤ hh ≤ 0x12 in 12-hour mode.
- Valid load: time_bcd = load_val on the next edge, prescaler cleared to 0, no sec_tick or day_carry that cycle. The next step therefore occurs TICK_DIV en-cycles later.
- Invalid load: time_bcd and prescaler unchanged (a coincident tick is lost), load_err = 1 for one cycle.
- Load is accepted even when en=0.
- en=0: prescaler frozen at its current value (not cleared) and no pulses. Re-enabling resumes the count from that value.
- rst mid-count or mid-load forces the reset values immediately, whatever the other inputs are.
- Pulses never stretch: each is high for exactly one clk cycle per event.

Optional Feature:
- Macro: BCD_TIME_ALARM_EN.
- Defined: adds ports alarm_set (in, 1), alarm_val (in, 24), alarm (out, 1).
  - The alarm register resets to 24'hFFFFFF, which never matches.
  - alarm_set latches alarm_val with no validation.
  - alarm pulses for one cycle together with sec_tick when the new time_bcd equals the alarm register. A load never triggers it.
- Undefined: the three ports and the alarm register do not exist.

Decomposition:
- Package bcd_time_pkg holds:
  - BCD field width constant (8);
  - field limit constants 8'h59, 8'h23, 8'h12, 8'h01;
  - the reset-time constants for 12-hour and 24-hour modes;
  - the validity-check function for a BCD field against a min/max.
- Sub-module bcd_field_counter: one two-digit BCD field.
  - Parameters MIN and MAX.
  - Inputs: step, up_dn, load, load_val.
  - Outputs: q, and wrap (combinational, asserted when step is applied at the boundary).
  - Instantiated three times and chained through wrap→step.

Test Plan:
- TICK_DIV=4, HOUR_MOD=24, reset, en=1, up → time_bcd 000000→000001 after 4 cycles. sec_tick high exactly 1 cycle per 4.
- Load 235959, up, en=1 → next step gives 000000 with day_carry=1 alongside sec_tick.
- HOUR_MOD=12: load 125959 up → 010000 with day_carry=1. Then down → 125959 with day_carry=1.
- Down from 010000 (24-hour mode) → 005959, no day_carry. Then load 000000 and step down → 235959 with day_carry.
- Invalid loads 006000, 240000 and 0A0000 → load_err pulses, time unchanged. Load 123456 coincident with the tick edge → time becomes 123456, no sec_tick, next step 4 cycles later.
- With BCD_TIME_ALARM_EN: alarm_set with 000003, reset count → alarm pulses once when time_bcd becomes 000003. Assert rst mid-count → all outputs return to their reset values without waiting for a clk edge.
